concat_skip_buffer: RTL

//  Sits directly upstream of concat. Captures main-path (skip) beats and branch-path beats,
//  re-times them into ordered pairs: layer_vld beat, then branch_vld beat exactly 1 cycle later.

---
 rtl/concat_skip_buffer_pkg.sv | 19 +
 rtl/nn_sync_fifo.sv | 60 ++++++
 rtl/concat_skip_buffer.sv | 113 +++++++++++
 3 files changed

// File: rtl/concat_skip_buffer_pkg.sv
// Shared definitions for the concat skip buffer: pairing FSM state encoding
// and a constant clog2 helper for sizing pointers and counters.
package concat_skip_buffer_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PAIR = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nn_sync_fifo.sv
// Synchronous FIFO with combinational head output; the consumer registers the
// head on the pop cycle. A write into a full FIFO is kept only if it also pops.
module nn_sync_fifo
  import concat_skip_buffer_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_rd_s;
  logic             do_wr_s;

  assign empty   = (count_r == CW'(0));
  assign full    = (count_r == CW'(DEPTH));
  assign do_rd_s = rd_en && !empty;
  assign do_wr_s = wr_en && (!full || do_rd_s);
  assign drop    = wr_en && !do_wr_s;
  assign dout    = mem_r[rd_ptr_r];
  assign count   = count_r;

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_wr_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_rd_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents beyond the pointers are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_wr_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/concat_skip_buffer.sv
// Re-times skip-path and branch-path beats into ordered pairs for concat:
// a layer beat, then the matching branch beat exactly one cycle later.
module concat_skip_buffer
  import concat_skip_buffer_pkg::*;
#(
  parameter  int N             = 8,
  parameter  int INPUT_CHANNEL = 1,
  parameter  int SKIP_DEPTH    = 16,
  parameter  int BR_DEPTH      = 4,
  localparam int W             = INPUT_CHANNEL * N,
  localparam int SCW           = clog2(SKIP_DEPTH) + 1,
  localparam int BCW           = clog2(BR_DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           skip_vld,
  input  logic [W-1:0]   skip_din,
  input  logic           br_vld,
  input  logic [W-1:0]   br_din,
  output logic           layer_vld,
  output logic [W-1:0]   layer_dout,
  output logic           branch_vld,
  output logic [W-1:0]   branch_dout,
  output logic [SCW-1:0] skip_count,
  output logic           ovf_err
);

  state_t         state_r;
  state_t         state_nx_s;
  logic           skip_pop_s;
  logic           br_pop_s;
  logic [W-1:0]   skip_head_s;
  logic [W-1:0]   br_head_s;
  logic           skip_empty_s;
  logic           br_empty_s;
  logic           skip_full_s;
  logic           br_full_s;
  logic           skip_drop_s;
  logic           br_drop_s;
  logic [BCW-1:0] br_count_s;
  logic           layer_vld_r;
  logic [W-1:0]   layer_dout_r;
  logic           branch_vld_r;
  logic [W-1:0]   branch_dout_r;
  logic           ovf_err_r;
  logic           unused_s;

  nn_sync_fifo #(.WIDTH(W), .DEPTH(SKIP_DEPTH)) u_skip_fifo (
    .clk(clk), .rst(rst), .wr_en(skip_vld), .din(skip_din), .rd_en(skip_pop_s),
    .dout(skip_head_s), .count(skip_count), .full(skip_full_s),
    .empty(skip_empty_s), .drop(skip_drop_s)
  );

  nn_sync_fifo #(.WIDTH(W), .DEPTH(BR_DEPTH)) u_br_fifo (
    .clk(clk), .rst(rst), .wr_en(br_vld), .din(br_din), .rd_en(br_pop_s),
    .dout(br_head_s), .count(br_count_s), .full(br_full_s),
    .empty(br_empty_s), .drop(br_drop_s)
  );

  assign unused_s = ^{skip_full_s, br_full_s, br_count_s};

  // Pairing FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nx_s;
  end

  // Pop skip only once a branch beat is waiting, so S_PAIR always has one to pop.
  always_comb begin
    state_nx_s = state_r;
    skip_pop_s = 1'b0;
    br_pop_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!skip_empty_s && !br_empty_s) begin
          skip_pop_s = 1'b1;
          state_nx_s = S_PAIR;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_PAIR: begin
        br_pop_s   = 1'b1;
        state_nx_s = S_IDLE;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Output registers: data buses hold between beats; overflow flag is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_vld_r   <= 1'b0;
      layer_dout_r  <= W'(0);
      branch_vld_r  <= 1'b0;
      branch_dout_r <= W'(0);
      ovf_err_r     <= 1'b0;
    end else begin
      layer_vld_r  <= skip_pop_s;
      branch_vld_r <= br_pop_s;
      if (skip_pop_s) layer_dout_r  <= skip_head_s;
      if (br_pop_s)   branch_dout_r <= br_head_s;
      ovf_err_r <= ovf_err_r | skip_drop_s | br_drop_s;
    end
  end

  assign layer_vld   = layer_vld_r;
  assign layer_dout  = layer_dout_r;
  assign branch_vld  = branch_vld_r;
  assign branch_dout = branch_dout_r;
  assign ovf_err     = ovf_err_r;

endmodule
